rv32i_mem_responder: RTL and testbench

- Memory-side responder for the rv32i core's load/store requests (address, read/write strobes, funct3, store data).
- Services each request over a 16-bit synchronous SRAM port: two beats for a word, one beat for a half or byte.
- Handles byte/halfword lane selection and load sign/zero extension.
- Flags misaligned or illegal accesses, then signals completion with a one-cycle done pulse.

---
 rtl/rv32i_mem_pkg.sv | 48 ++++
 rtl/sign_ext.sv | 12 +
 rtl/rv32i_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_rv32i_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared encodings for the rv32i memory responder.
// funct3 sizes, FSM states and the access legality check.
package rv32i_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_LO   = 3'd1;
    localparam logic [2:0] S_RD_HI   = 3'd2;
    localparam logic [2:0] S_RD_LAST = 3'd3;
    localparam logic [2:0] S_WR_LO   = 3'd4;
    localparam logic [2:0] S_WR_HI   = 3'd5;
    localparam logic [2:0] S_RESP    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_RD_LO   = S_RD_LO,
        ST_RD_HI   = S_RD_HI,
        ST_RD_LAST = S_RD_LAST,
        ST_WR_LO   = S_WR_LO,
        ST_WR_HI   = S_WR_HI,
        ST_RESP    = S_RESP
    } state_e;

    // Unsigned sizes exist only for loads.
    function automatic logic access_ok(
        input logic       is_load,
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic ok_f3;
        logic ok_al;
        case (f3)
            F3_B:    begin ok_f3 = 1'b1;    ok_al = 1'b1;      end
            F3_H:    begin ok_f3 = 1'b1;    ok_al = ~a[0];     end
            F3_W:    begin ok_f3 = 1'b1;    ok_al = (a == 2'b00); end
            F3_BU:   begin ok_f3 = is_load; ok_al = 1'b1;      end
            F3_HU:   begin ok_f3 = is_load; ok_al = ~a[0];     end
            default: begin ok_f3 = 1'b0;    ok_al = 1'b1;      end
        endcase
        return ok_f3 & ok_al;
    endfunction

endpackage

// File: rtl/sign_ext.sv
// Sign extension of an INPUT_LEN-bit value to OUTPUT_LEN bits.
module sign_ext #(
    parameter int INPUT_LEN  = 8,
    parameter int OUTPUT_LEN = 32
) (
    input  logic [INPUT_LEN-1:0]  data_i,
    output logic [OUTPUT_LEN-1:0] data_o
);

    assign data_o = {{(OUTPUT_LEN-INPUT_LEN){data_i[INPUT_LEN-1]}}, data_i};

endmodule

// File: rtl/rv32i_mem_responder.sv
// Services rv32i load/store requests over a 16-bit synchronous SRAM,
// with lane selection, load extension and misalignment detection.
module rv32i_mem_responder
    import rv32i_mem_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MEM_ADDR_BITS = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [XLEN-1:0]          memory_addr_i,
    input  logic                     memory_read_i,
    input  logic                     memory_write_i,
    input  logic [2:0]               funct3_i,
    input  logic [XLEN-1:0]          write_data_i,
    output logic [XLEN-1:0]          read_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [MEM_ADDR_BITS-1:0] sram_addr_o,
    output logic                     sram_re_o,
    output logic                     sram_we_o,
    output logic [1:0]               sram_be_o,
    output logic [15:0]              sram_data_o,
    input  logic [15:0]              sram_data_i
);

    state_e                   state_q, state_d;
    logic [MEM_ADDR_BITS:0]   addr_q, addr_d;
    logic [2:0]               f3_q, f3_d;
    logic [XLEN-1:0]          wd_q, wd_d;
    logic [15:0]              lo_q, lo_d;
    logic                     err_q, err_d;
    logic [XLEN-1:0]          rdata_q, rdata_d;

    logic [MEM_ADDR_BITS-1:0] hw;
    logic [MEM_ADDR_BITS-1:0] hw_hi;
    logic [7:0]               byte_sel;
    logic [XLEN-1:0]          sext_b;
    logic [XLEN-1:0]          sext_h;
    logic [XLEN-1:0]          result;
    logic                     unused_addr;

    // Byte address bits above the SRAM window alias onto it.
    assign unused_addr = ^memory_addr_i[XLEN-1:MEM_ADDR_BITS+1];

    assign hw       = addr_q[MEM_ADDR_BITS:1];
    assign hw_hi    = {hw[MEM_ADDR_BITS-1:1], 1'b1};
    assign byte_sel = addr_q[0] ? sram_data_i[15:8] : sram_data_i[7:0];

    sign_ext #(.INPUT_LEN(8), .OUTPUT_LEN(XLEN)) u_sext_b (
        .data_i (byte_sel),
        .data_o (sext_b)
    );

    sign_ext #(.INPUT_LEN(16), .OUTPUT_LEN(XLEN)) u_sext_h (
        .data_i (sram_data_i),
        .data_o (sext_h)
    );

    always_comb begin
        unique case (f3_q)
            F3_B:    result = sext_b;
            F3_BU:   result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    result = sext_h;
            F3_HU:   result = {{(XLEN-16){1'b0}}, sram_data_i};
            default: result = {sram_data_i, lo_q};
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wd_d    = wd_q;
        lo_d    = lo_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (memory_read_i || memory_write_i) begin
                    addr_d = memory_addr_i[MEM_ADDR_BITS:0];
                    f3_d   = funct3_i;
                    wd_d   = write_data_i;
                    if ((memory_read_i && memory_write_i) ||
                        !access_ok(memory_read_i, funct3_i,
                                   memory_addr_i[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = memory_read_i ? ST_RD_LO : ST_WR_LO;
                    end
                end
            end
            ST_RD_LO:
                state_d = (f3_q == F3_W) ? ST_RD_HI : ST_RD_LAST;
            ST_RD_HI: begin
                lo_d    = sram_data_i;
                state_d = ST_RD_LAST;
            end
            ST_RD_LAST: begin
                rdata_d = result;
                state_d = ST_RESP;
            end
            ST_WR_LO:
                state_d = (f3_q == F3_W) ? ST_WR_HI : ST_RESP;
            ST_WR_HI:
                state_d = ST_RESP;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            wd_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wd_q    <= wd_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        sram_addr_o = '0;
        sram_re_o   = 1'b0;
        sram_we_o   = 1'b0;
        sram_be_o   = 2'b00;
        sram_data_o = '0;
        unique case (state_q)
            ST_RD_LO: begin
                sram_re_o   = 1'b1;
                sram_addr_o = hw;
            end
            ST_RD_HI: begin
                sram_re_o   = 1'b1;
                sram_addr_o = hw_hi;
            end
            ST_WR_LO: begin
                sram_we_o   = 1'b1;
                sram_addr_o = hw;
                if (f3_q == F3_B) begin
                    sram_be_o   = addr_q[0] ? 2'b10 : 2'b01;
                    sram_data_o = {wd_q[7:0], wd_q[7:0]};
                end else begin
                    sram_be_o   = 2'b11;
                    sram_data_o = wd_q[15:0];
                end
            end
            ST_WR_HI: begin
                sram_we_o   = 1'b1;
                sram_addr_o = hw_hi;
                sram_be_o   = 2'b11;
                sram_data_o = wd_q[XLEN-1:16];
            end
            default: ;
        endcase
    end

    assign read_data_o = rdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_RESP);
    assign error_o     = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_rv32i_mem_responder.sv
// Directed bench for rv32i_mem_responder with a behavioural
// 16-bit synchronous SRAM and immediate-assertion checks.
module tb_rv32i_mem_responder;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] memory_addr_i;
    logic        memory_read_i;
    logic        memory_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [15:0] sram_addr_o;
    logic        sram_re_o;
    logic        sram_we_o;
    logic [1:0]  sram_be_o;
    logic [15:0] sram_data_o;
    logic [15:0] sram_data_i;

    logic [15:0] mem [0:65535];
    logic        preload;

    int n_checks = 0;
    int n_fails  = 0;

    int          lat;
    int          re_cnt;
    int          we_cnt;
    logic        err_seen;
    logic        busy1;
    logic [15:0] re_a [0:3];
    logic [15:0] we_a;
    logic [1:0]  we_be;
    logic [15:0] we_d;

    always #5 clk = ~clk;

    rv32i_mem_responder dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .memory_addr_i  (memory_addr_i),
        .memory_read_i  (memory_read_i),
        .memory_write_i (memory_write_i),
        .funct3_i       (funct3_i),
        .write_data_i   (write_data_i),
        .read_data_o    (read_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .sram_addr_o    (sram_addr_o),
        .sram_re_o      (sram_re_o),
        .sram_we_o      (sram_we_o),
        .sram_be_o      (sram_be_o),
        .sram_data_o    (sram_data_o),
        .sram_data_i    (sram_data_i)
    );

    always @(posedge clk) begin
        if (preload) begin
            mem[8] <= 16'hBEEF;
            mem[9] <= 16'hDEAD;
        end else begin
            if (sram_re_o)
                sram_data_i <= mem[sram_addr_o];
            if (sram_we_o) begin
                if (sram_be_o[0])
                    mem[sram_addr_o][7:0] <= sram_data_o[7:0];
                if (sram_be_o[1])
                    mem[sram_addr_o][15:8] <= sram_data_o[15:8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and watch up to 8 cycles for done_o.
    task automatic req(input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
        logic seen;
        @(negedge clk);
        memory_read_i  = rd;
        memory_write_i = wr;
        funct3_i       = f3;
        memory_addr_i  = a;
        write_data_i   = wd;
        @(posedge clk);
        #1;
        memory_read_i  = 1'b0;
        memory_write_i = 1'b0;
        memory_addr_i  = 32'hFFFF_FFFF;
        write_data_i   = 32'h0;
        lat = 0; re_cnt = 0; we_cnt = 0; err_seen = 1'b0;
        busy1 = 1'b0; seen = 1'b0;
        we_a = '0; we_be = '0; we_d = '0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (c == 1)
                busy1 = busy_o;
            if (sram_re_o) begin
                if (re_cnt < 4)
                    re_a[re_cnt] = sram_addr_o;
                re_cnt++;
            end
            if (sram_we_o) begin
                if (we_cnt == 0) begin
                    we_a  = sram_addr_o;
                    we_be = sram_be_o;
                    we_d  = sram_data_o;
                end
                we_cnt++;
            end
            if (done_o) begin
                lat      = c;
                err_seen = error_o;
                seen     = 1'b1;
            end
        end
        chk("busy_c1", {31'b0, busy1}, 32'd1);
    endtask

    task automatic err_case(input string tag, input logic rd,
                            input logic wr, input logic [2:0] f3,
                            input logic [31:0] a);
        req(rd, wr, f3, a, 32'h5555_AAAA);
        chk({tag, "_lat"}, lat, 32'd1);
        chk({tag, "_err"}, {31'b0, err_seen}, 32'd1);
        chk({tag, "_strobes"}, re_cnt + we_cnt, 32'd0);
        chk({tag, "_rdata"}, read_data_o, 32'h0000_00BE);
    endtask

    initial begin
        reset_i        = 1'b1;
        preload        = 1'b1;
        memory_addr_i  = '0;
        memory_read_i  = 1'b0;
        memory_write_i = 1'b0;
        funct3_i       = '0;
        write_data_i   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", read_data_o, 32'h0);
        chk("rst_ctl", {26'b0, busy_o, done_o, error_o, sram_re_o,
                        sram_we_o, 1'b0}, 32'h0);
        chk("rst_be", {30'b0, sram_be_o}, 32'h0);
        chk("rst_addr", {16'b0, sram_addr_o}, 32'h0);
        chk("rst_wdata", {16'b0, sram_data_o}, 32'h0);
        reset_i = 1'b0;
        preload = 1'b0;

        req(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
        chk("lw_lat", lat, 32'd4);
        chk("lw_err", {31'b0, err_seen}, 32'd0);
        chk("lw_nre", re_cnt, 32'd2);
        chk("lw_a0", {16'b0, re_a[0]}, 32'd8);
        chk("lw_a1", {16'b0, re_a[1]}, 32'd9);
        chk("lw_data", read_data_o, 32'hDEAD_BEEF);

        req(1'b1, 1'b0, 3'b000, 32'h0000_0011, 32'h0);
        chk("lb_lat", lat, 32'd3);
        chk("lb_a0", {16'b0, re_a[0]}, 32'd8);
        chk("lb_data", read_data_o, 32'hFFFF_FFBE);

        req(1'b1, 1'b0, 3'b100, 32'h0000_0011, 32'h0);
        chk("lbu_lat", lat, 32'd3);
        chk("lbu_data", read_data_o, 32'h0000_00BE);

        req(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h1234_56A5);
        chk("sb_lat", lat, 32'd2);
        chk("sb_nwe", we_cnt, 32'd1);
        chk("sb_addr", {16'b0, we_a}, 32'd9);
        chk("sb_be", {30'b0, we_be}, 32'd2);
        chk("sb_data", {16'b0, we_d}, 32'h0000_A5A5);
        chk("sb_mem", {16'b0, mem[9]}, 32'h0000_A5AD);
        chk("sb_rdata", read_data_o, 32'h0000_00BE);

        err_case("sw_mis", 1'b0, 1'b1, 3'b010, 32'h0000_0002);
        err_case("lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0001);
        err_case("f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0000);
        err_case("rd_wr", 1'b1, 1'b1, 3'b010, 32'h0000_0010);
        err_case("sbu", 1'b0, 1'b1, 3'b100, 32'h0000_0010);

        req(1'b0, 1'b1, 3'b010, 32'h0002_0010, 32'hCAFE_F00D);
        chk("sw_lat", lat, 32'd3);
        chk("sw_nwe", we_cnt, 32'd2);
        chk("sw_addr", {16'b0, we_a}, 32'd8);
        chk("sw_be", {30'b0, we_be}, 32'd3);
        chk("sw_mem8", {16'b0, mem[8]}, 32'h0000_F00D);
        chk("sw_mem9", {16'b0, mem[9]}, 32'h0000_CAFE);

        req(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
        chk("lw2_data", read_data_o, 32'hCAFE_F00D);

        req(1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0);
        chk("lh_lat", lat, 32'd3);
        chk("lh_data", read_data_o, 32'hFFFF_CAFE);

        req(1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'h0);
        chk("lhu_data", read_data_o, 32'h0000_CAFE);

        req(1'b0, 1'b1, 3'b001, 32'h0000_0014, 32'h9999_1234);
        chk("sh_lat", lat, 32'd2);
        chk("sh_be", {30'b0, we_be}, 32'd3);
        chk("sh_addr", {16'b0, we_a}, 32'd10);
        chk("sh_mem", {16'b0, mem[10]}, 32'h0000_1234);

        // Abort a word load while the high half is being fetched.
        @(negedge clk);
        memory_read_i = 1'b1;
        funct3_i      = 3'b010;
        memory_addr_i = 32'h0000_0010;
        @(posedge clk);
        #1;
        memory_read_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_rdhi", {15'b0, sram_re_o, sram_addr_o}, 32'h0001_0009);
        reset_i = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy_o}, 32'd0);
        chk("abort_done", {31'b0, done_o}, 32'd0);
        chk("abort_re", {31'b0, sram_re_o}, 32'd0);
        chk("abort_rdata", read_data_o, 32'h0);
        reset_i = 1'b0;

        req(1'b1, 1'b0, 3'b001, 32'h0000_0010, 32'h0);
        chk("post_lat", lat, 32'd3);
        chk("post_err", {31'b0, err_seen}, 32'd0);
        chk("post_data", read_data_o, 32'hFFFF_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
